// File: rtl/issue_queue_age.sv
// issue_queue_age: parametrised age-ordered integer issue queue.
// Tracks operand tags, readiness, port eligibility and relative age per slot;
// each issue port grants its oldest eligible entry, ports resolved 0..N-1.
// Optional build macro IQ_BYPASS_WAKEUP_EN: same-cycle wakeup broadcasts
// also count toward issue eligibility (back-to-back dependent issue).
module issue_queue_age #(
    parameter int unsigned ENTRIES        = 16,
    parameter int unsigned DISPATCH_WIDTH = 4,
    parameter int unsigned ISSUE_WIDTH    = 3,
    parameter int unsigned WB_WIDTH       = 3,
    parameter int unsigned TAG_W          = 6,
    parameter int unsigned PAYLOAD_W      = 64
) (
    input  logic                                       clock,
    input  logic                                       reset,
    input  logic                                       flush,
    input  logic [DISPATCH_WIDTH-1:0]                  dispatch_valid,
    output logic                                       dispatch_ready,
    input  logic [DISPATCH_WIDTH-1:0][TAG_W-1:0]       dispatch_rs1_tag,
    input  logic [DISPATCH_WIDTH-1:0][TAG_W-1:0]       dispatch_rs2_tag,
    input  logic [DISPATCH_WIDTH-1:0]                  dispatch_rs1_rdy,
    input  logic [DISPATCH_WIDTH-1:0]                  dispatch_rs2_rdy,
    input  logic [DISPATCH_WIDTH-1:0][ISSUE_WIDTH-1:0] dispatch_port_mask,
    input  logic [DISPATCH_WIDTH-1:0][PAYLOAD_W-1:0]   dispatch_payload,
    input  logic [WB_WIDTH-1:0]                        wb_valid,
    input  logic [WB_WIDTH-1:0][TAG_W-1:0]             wb_tag,
    output logic [ISSUE_WIDTH-1:0]                     issue_valid,
    input  logic [ISSUE_WIDTH-1:0]                     issue_ready,
    output logic [ISSUE_WIDTH-1:0][PAYLOAD_W-1:0]      issue_payload,
    output logic [$clog2(ENTRIES):0]                   free_count
);

    localparam int unsigned CNT_W = $clog2(ENTRIES) + 1;
    localparam int unsigned IDX_W = $clog2(ENTRIES);
    localparam logic [CNT_W-1:0] ENTRIES_C  = CNT_W'(ENTRIES);
    localparam logic [CNT_W-1:0] DISPATCH_C = CNT_W'(DISPATCH_WIDTH);

    logic [ENTRIES-1:0]                  valid_q;
    logic [ENTRIES-1:0]                  rs1_rdy_q;
    logic [ENTRIES-1:0]                  rs2_rdy_q;
    logic [ENTRIES-1:0][TAG_W-1:0]       rs1_tag_q;
    logic [ENTRIES-1:0][TAG_W-1:0]       rs2_tag_q;
    logic [ENTRIES-1:0][ISSUE_WIDTH-1:0] port_mask_q;
    logic [ENTRIES-1:0][PAYLOAD_W-1:0]   payload_q;
    logic [ENTRIES-1:0][ENTRIES-1:0]     older_q;      // older_q[i][j]: entry i older than entry j
    logic [CNT_W-1:0]                    free_count_q;

    logic [ENTRIES-1:0]                  wake1;
    logic [ENTRIES-1:0]                  wake2;
    logic [DISPATCH_WIDTH-1:0]           lane_wake1;
    logic [DISPATCH_WIDTH-1:0]           lane_wake2;
    logic [ENTRIES-1:0]                  op_ready;

    logic [ISSUE_WIDTH-1:0][ENTRIES-1:0] grant;
    logic [ENTRIES-1:0]                  taken;
    logic [ENTRIES-1:0]                  elig;
    logic                                blocked;
    logic [ENTRIES-1:0]                  issued_mask;
    logic [CNT_W-1:0]                    issue_cnt;

    logic                                fire;
    logic [ENTRIES-1:0]                  avail;
    logic                                found;
    logic [DISPATCH_WIDTH-1:0]           lane_go;
    logic [DISPATCH_WIDTH-1:0][IDX_W-1:0] lane_slot;
    logic [CNT_W-1:0]                    disp_cnt;

    assign free_count     = free_count_q;
    assign dispatch_ready = (free_count_q >= DISPATCH_C);

    // Tag-match every broadcast against resident operands and dispatching lanes
    always_comb begin
        wake1      = '0;
        wake2      = '0;
        lane_wake1 = '0;
        lane_wake2 = '0;
        for (int unsigned w = 0; w < WB_WIDTH; w++) begin
            for (int unsigned i = 0; i < ENTRIES; i++) begin
                if (wb_valid[w] && (wb_tag[w] == rs1_tag_q[i])) wake1[i] = 1'b1;
                if (wb_valid[w] && (wb_tag[w] == rs2_tag_q[i])) wake2[i] = 1'b1;
            end
            for (int unsigned l = 0; l < DISPATCH_WIDTH; l++) begin
                if (wb_valid[w] && (wb_tag[w] == dispatch_rs1_tag[l])) lane_wake1[l] = 1'b1;
                if (wb_valid[w] && (wb_tag[w] == dispatch_rs2_tag[l])) lane_wake2[l] = 1'b1;
            end
        end
    end

`ifdef IQ_BYPASS_WAKEUP_EN
    assign op_ready = valid_q & (rs1_rdy_q | wake1) & (rs2_rdy_q | wake2);
`else
    assign op_ready = valid_q & rs1_rdy_q & rs2_rdy_q;
`endif

    // Serial per-port oldest-first select; a stalled port leaves its candidate to later ports
    always_comb begin
        taken         = '0;
        elig          = '0;
        blocked       = 1'b0;
        grant         = '0;
        issue_valid   = '0;
        issue_payload = '0;
        issue_cnt     = '0;
        for (int unsigned p = 0; p < ISSUE_WIDTH; p++) begin
            for (int unsigned i = 0; i < ENTRIES; i++) begin
                elig[i] = op_ready[i] & port_mask_q[i][p] & ~taken[i];
            end
            if (issue_ready[p] && !flush) begin
                for (int unsigned i = 0; i < ENTRIES; i++) begin
                    blocked = 1'b0;
                    for (int unsigned j = 0; j < ENTRIES; j++) begin
                        if (elig[j] && older_q[j][i]) blocked = 1'b1;
                    end
                    if (elig[i] && !blocked) grant[p][i] = 1'b1;
                end
            end
            taken          = taken | grant[p];
            issue_valid[p] = |grant[p];
            for (int unsigned i = 0; i < ENTRIES; i++) begin
                if (grant[p][i]) issue_payload[p] = payload_q[i];
            end
        end
        issued_mask = taken;
        for (int unsigned i = 0; i < ENTRIES; i++) begin
            issue_cnt = issue_cnt + CNT_W'(issued_mask[i]);
        end
    end

    // Allocate valid lanes, in lane order, to the lowest-indexed free slots
    always_comb begin
        fire      = dispatch_ready & (|dispatch_valid) & ~flush;
        avail     = ~valid_q;
        found     = 1'b0;
        lane_go   = '0;
        lane_slot = '0;
        disp_cnt  = '0;
        for (int unsigned l = 0; l < DISPATCH_WIDTH; l++) begin
            if (fire && dispatch_valid[l]) begin
                found = 1'b0;
                for (int unsigned i = 0; i < ENTRIES; i++) begin
                    if (!found && avail[i]) begin
                        lane_slot[l] = IDX_W'(i);
                        avail[i]     = 1'b0;
                        found        = 1'b1;
                    end
                end
                lane_go[l] = found;
                disp_cnt   = disp_cnt + CNT_W'(found);
            end
        end
    end

    // Entry state, readiness, age matrix and free count; flush overrides everything
    always_ff @(posedge clock) begin
        if (reset || flush) begin
            valid_q      <= '0;
            rs1_rdy_q    <= '0;
            rs2_rdy_q    <= '0;
            older_q      <= '0;
            free_count_q <= ENTRIES_C;
        end else begin
            valid_q <= valid_q & ~issued_mask;
            for (int unsigned i = 0; i < ENTRIES; i++) begin
                if (valid_q[i]) begin
                    rs1_rdy_q[i] <= rs1_rdy_q[i] | wake1[i];
                    rs2_rdy_q[i] <= rs2_rdy_q[i] | wake2[i];
                end
            end
            // Later lanes' writes come after earlier ones, so a new entry's row is cleared
            // first and then re-marked older than every later lane of the same group.
            for (int unsigned l = 0; l < DISPATCH_WIDTH; l++) begin
                if (lane_go[l]) begin
                    valid_q[lane_slot[l]]   <= 1'b1;
                    rs1_rdy_q[lane_slot[l]] <= dispatch_rs1_rdy[l] | lane_wake1[l];
                    rs2_rdy_q[lane_slot[l]] <= dispatch_rs2_rdy[l] | lane_wake2[l];
                    for (int unsigned j = 0; j < ENTRIES; j++) begin
                        older_q[lane_slot[l]][j] <= 1'b0;
                        older_q[j][lane_slot[l]] <= valid_q[j];
                    end
                    for (int unsigned m = 0; m < l; m++) begin
                        if (lane_go[m]) older_q[lane_slot[m]][lane_slot[l]] <= 1'b1;
                    end
                end
            end
            free_count_q <= free_count_q - disp_cnt + issue_cnt;
        end
    end

    // Tags, port mask and payload are captured on allocation and held while resident
    always_ff @(posedge clock) begin
        for (int unsigned l = 0; l < DISPATCH_WIDTH; l++) begin
            if (lane_go[l]) begin
                rs1_tag_q[lane_slot[l]]   <= dispatch_rs1_tag[l];
                rs2_tag_q[lane_slot[l]]   <= dispatch_rs2_tag[l];
                port_mask_q[lane_slot[l]] <= dispatch_port_mask[l];
                payload_q[lane_slot[l]]   <= dispatch_payload[l];
            end
        end
    end

endmodule

// File: tb/tb_issue_queue_age.sv
// Self-checking bench for issue_queue_age: directed scenarios plus randomized
// traffic compared against a sequence-number based reference model.
// Honours IQ_BYPASS_WAKEUP_EN the same way as the design.
module tb_issue_queue_age;

    localparam int E  = 16;
    localparam int DW = 4;
    localparam int NI = 3;
    localparam int WW = 3;
    localparam int TW = 6;
    localparam int PW = 64;

    logic                     clock = 1'b0;
    logic                     reset;
    logic                     flush;
    logic [DW-1:0]            dispatch_valid;
    logic                     dispatch_ready;
    logic [DW-1:0][TW-1:0]    dispatch_rs1_tag;
    logic [DW-1:0][TW-1:0]    dispatch_rs2_tag;
    logic [DW-1:0]            dispatch_rs1_rdy;
    logic [DW-1:0]            dispatch_rs2_rdy;
    logic [DW-1:0][NI-1:0]    dispatch_port_mask;
    logic [DW-1:0][PW-1:0]    dispatch_payload;
    logic [WW-1:0]            wb_valid;
    logic [WW-1:0][TW-1:0]    wb_tag;
    logic [NI-1:0]            issue_valid;
    logic [NI-1:0]            issue_ready;
    logic [NI-1:0][PW-1:0]    issue_payload;
    logic [$clog2(E):0]       free_count;

    always #5 clock = ~clock;

    issue_queue_age #(
        .ENTRIES(E), .DISPATCH_WIDTH(DW), .ISSUE_WIDTH(NI),
        .WB_WIDTH(WW), .TAG_W(TW), .PAYLOAD_W(PW)
    ) dut (
        .clock(clock), .reset(reset), .flush(flush),
        .dispatch_valid(dispatch_valid), .dispatch_ready(dispatch_ready),
        .dispatch_rs1_tag(dispatch_rs1_tag), .dispatch_rs2_tag(dispatch_rs2_tag),
        .dispatch_rs1_rdy(dispatch_rs1_rdy), .dispatch_rs2_rdy(dispatch_rs2_rdy),
        .dispatch_port_mask(dispatch_port_mask), .dispatch_payload(dispatch_payload),
        .wb_valid(wb_valid), .wb_tag(wb_tag),
        .issue_valid(issue_valid), .issue_ready(issue_ready),
        .issue_payload(issue_payload), .free_count(free_count)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: a bag of resident uops ordered by dispatch sequence number
    bit          m_v   [E];
    bit          m_r1  [E];
    bit          m_r2  [E];
    logic [TW-1:0] m_t1 [E];
    logic [TW-1:0] m_t2 [E];
    logic [NI-1:0] m_mask [E];
    logic [PW-1:0] m_pl [E];
    longint      m_seq [E];
    longint      seq_ctr = 0;
    bit          exp_iv  [NI];
    int          exp_idx [NI];
    logic [PW-1:0] exp_pl [NI];

    function automatic bit wb_hit(input logic [TW-1:0] t);
        for (int w = 0; w < WW; w++) if (wb_valid[w] && wb_tag[w] == t) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit m_ready(input int i);
`ifdef IQ_BYPASS_WAKEUP_EN
        return (m_r1[i] || wb_hit(m_t1[i])) && (m_r2[i] || wb_hit(m_t2[i]));
`else
        return m_r1[i] && m_r2[i];
`endif
    endfunction

    function automatic int m_free();
        int n = 0;
        for (int i = 0; i < E; i++) if (!m_v[i]) n++;
        return n;
    endfunction

    task automatic predict();
        bit taken [E];
        for (int i = 0; i < E; i++) taken[i] = 1'b0;
        for (int p = 0; p < NI; p++) begin
            int best = -1;
            if (issue_ready[p] && !flush) begin
                for (int i = 0; i < E; i++) begin
                    if (m_v[i] && m_ready(i) && m_mask[i][p] && !taken[i] &&
                        (best < 0 || m_seq[i] < m_seq[best])) best = i;
                end
            end
            exp_iv[p]  = (best >= 0);
            exp_idx[p] = best;
            exp_pl[p]  = (best >= 0) ? m_pl[best] : '0;
            if (best >= 0) taken[best] = 1'b1;
        end
    endtask

    task automatic model_check();
        int nf = m_free();
        predict();
        check("free_count", 64'(free_count), 64'(nf));
        check("dispatch_ready", 64'(dispatch_ready), 64'(nf >= DW));
        for (int p = 0; p < NI; p++) begin
            check($sformatf("issue_valid%0d", p), 64'(issue_valid[p]), 64'(exp_iv[p]));
            if (exp_iv[p]) check($sformatf("issue_payload%0d", p), issue_payload[p], exp_pl[p]);
        end
    endtask

    task automatic model_edge();
        int nf;
        predict();
        if (reset || flush) begin
            for (int i = 0; i < E; i++) m_v[i] = 1'b0;
            return;
        end
        nf = m_free();
        for (int p = 0; p < NI; p++) if (exp_iv[p]) m_v[exp_idx[p]] = 1'b0;
        for (int i = 0; i < E; i++) begin
            if (m_v[i]) begin
                if (wb_hit(m_t1[i])) m_r1[i] = 1'b1;
                if (wb_hit(m_t2[i])) m_r2[i] = 1'b1;
            end
        end
        if (nf >= DW) begin
            for (int l = 0; l < DW; l++) begin
                if (dispatch_valid[l]) begin
                    int s = -1;
                    for (int i = 0; i < E; i++) if (s < 0 && !m_v[i]) s = i;
                    if (s >= 0) begin
                        m_v[s]    = 1'b1;
                        m_r1[s]   = dispatch_rs1_rdy[l] || wb_hit(dispatch_rs1_tag[l]);
                        m_r2[s]   = dispatch_rs2_rdy[l] || wb_hit(dispatch_rs2_tag[l]);
                        m_t1[s]   = dispatch_rs1_tag[l];
                        m_t2[s]   = dispatch_rs2_tag[l];
                        m_mask[s] = dispatch_port_mask[l];
                        m_pl[s]   = dispatch_payload[l];
                        m_seq[s]  = seq_ctr;
                        seq_ctr++;
                    end
                end
            end
        end
    endtask

    task automatic idle();
        reset              = 1'b0;
        flush              = 1'b0;
        dispatch_valid     = '0;
        dispatch_rs1_tag   = '0;
        dispatch_rs2_tag   = '0;
        dispatch_rs1_rdy   = '0;
        dispatch_rs2_rdy   = '0;
        dispatch_port_mask = '0;
        dispatch_payload   = '0;
        wb_valid           = '0;
        wb_tag             = '0;
        issue_ready        = '1;
    endtask

    task automatic set_lane(input int l, input bit r1, input logic [TW-1:0] t1,
                            input bit r2, input logic [TW-1:0] t2,
                            input logic [NI-1:0] m, input logic [PW-1:0] pl);
        dispatch_valid[l]     = 1'b1;
        dispatch_rs1_rdy[l]   = r1;
        dispatch_rs1_tag[l]   = t1;
        dispatch_rs2_rdy[l]   = r2;
        dispatch_rs2_tag[l]   = t2;
        dispatch_port_mask[l] = m;
        dispatch_payload[l]   = pl;
    endtask

    task automatic settle();
        @(negedge clock);
        model_check();
    endtask

    task automatic advance();
        @(posedge clock);
        model_edge();
        #1;
    endtask

    logic [PW-1:0] pl_ctr;

    initial begin
        for (int i = 0; i < E; i++) begin
            m_v[i] = 1'b0; m_r1[i] = 1'b0; m_r2[i] = 1'b0; m_t1[i] = '0; m_t2[i] = '0;
            m_mask[i] = '0; m_pl[i] = '0; m_seq[i] = 0;
        end
        idle();
        reset = 1'b1;
        advance();
        advance();
        reset = 1'b0;

        // Reset state
        settle();
        check("rst_free", 64'(free_count), 64'd16);
        check("rst_dready", 64'(dispatch_ready), 64'd1);
        check("rst_iv", 64'(issue_valid), 64'd0);
        check("rst_pl0", issue_payload[0], 64'd0);
        advance();

        // Four ready ALU uops: issue 1,2,3 then 4
        idle();
        for (int l = 0; l < DW; l++) set_lane(l, 1'b1, 6'd0, 1'b1, 6'd0, 3'b111, 64'(l + 1));
        settle();
        advance();
        idle();
        settle();
        check("t1_free12", 64'(free_count), 64'd12);
        check("t1_pl0", issue_payload[0], 64'd1);
        check("t1_pl1", issue_payload[1], 64'd2);
        check("t1_pl2", issue_payload[2], 64'd3);
        advance();
        settle();
        check("t1_free15", 64'(free_count), 64'd15);
        check("t1_iv_b", 64'(issue_valid), 64'b001);
        check("t1_pl0_b", issue_payload[0], 64'd4);
        advance();
        settle();
        check("t1_free16", 64'(free_count), 64'd16);
        advance();

        // Fill with uops waiting on tag 5; full queue ignores dispatch; wakeup drains oldest first
        for (int g = 0; g < 4; g++) begin
            idle();
            for (int l = 0; l < DW; l++)
                set_lane(l, 1'b0, 6'd5, 1'b1, 6'd0, 3'b111, 64'(256 + g * 4 + l));
            settle();
            advance();
        end
        idle();
        set_lane(0, 1'b1, 6'd0, 1'b1, 6'd0, 3'b111, 64'h999);
        settle();
        check("t2_full_dready", 64'(dispatch_ready), 64'd0);
        check("t2_full_free", 64'(free_count), 64'd0);
        advance();
        idle();
        wb_valid[0] = 1'b1;
        wb_tag[0]   = 6'd5;
        settle();
`ifdef IQ_BYPASS_WAKEUP_EN
        check("t2_wakeN_pl0", issue_payload[0], 64'h100);
        check("t2_wakeN_pl2", issue_payload[2], 64'h102);
`else
        check("t2_wakeN_iv", 64'(issue_valid), 64'd0);
`endif
        advance();
        idle();
        settle();
`ifdef IQ_BYPASS_WAKEUP_EN
        check("t2_wakeN1_pl0", issue_payload[0], 64'h103);
`else
        check("t2_wakeN1_pl0", issue_payload[0], 64'h100);
        check("t2_wakeN1_pl2", issue_payload[2], 64'h102);
`endif
        advance();
        for (int c = 0; c < 6; c++) begin
            settle();
            advance();
        end
        settle();
        check("t2_drained", 64'(free_count), 64'd16);
        advance();

        // A(001) B(001) C(111): port0=A, port1=C, port2 idle; then port0=B
        idle();
        set_lane(0, 1'b1, 6'd0, 1'b1, 6'd0, 3'b001, 64'hA);
        set_lane(1, 1'b1, 6'd0, 1'b1, 6'd0, 3'b001, 64'hB);
        set_lane(2, 1'b1, 6'd0, 1'b1, 6'd0, 3'b111, 64'hC);
        settle();
        advance();
        idle();
        settle();
        check("t3_iv", 64'(issue_valid), 64'b011);
        check("t3_pl0", issue_payload[0], 64'hA);
        check("t3_pl1", issue_payload[1], 64'hC);
        advance();
        settle();
        check("t3_iv_b", 64'(issue_valid), 64'b001);
        check("t3_pl0_b", issue_payload[0], 64'hB);
        advance();

        // Only port 1 ready: it takes the oldest, the rest keep their order
        idle();
        for (int l = 0; l < 3; l++) set_lane(l, 1'b1, 6'd0, 1'b1, 6'd0, 3'b111, 64'(65 + l));
        settle();
        advance();
        idle();
        issue_ready = 3'b010;
        settle();
        check("t4_iv", 64'(issue_valid), 64'b010);
        check("t4_pl1", issue_payload[1], 64'h41);
        advance();
        idle();
        settle();
        check("t4_iv_b", 64'(issue_valid), 64'b011);
        check("t4_pl0_b", issue_payload[0], 64'h42);
        check("t4_pl1_b", issue_payload[1], 64'h43);
        advance();

        // Wakeup in the dispatch cycle is captured
        idle();
        set_lane(0, 1'b1, 6'd0, 1'b0, 6'd9, 3'b111, 64'h55);
        wb_valid[2] = 1'b1;
        wb_tag[2]   = 6'd9;
        settle();
        advance();
        idle();
        settle();
        check("t5_iv", 64'(issue_valid), 64'b001);
        check("t5_pl0", issue_payload[0], 64'h55);
        advance();

        // Flush beats concurrent dispatch and issue
        idle();
        for (int l = 0; l < DW; l++) set_lane(l, 1'b0, 6'd7, 1'b1, 6'd0, 3'b111, 64'(96 + l));
        settle();
        advance();
        idle();
        for (int l = 0; l < DW; l++) set_lane(l, 1'b1, 6'd0, 1'b1, 6'd0, 3'b111, 64'(112 + l));
        wb_valid[0] = 1'b1;
        wb_tag[0]   = 6'd7;
        flush = 1'b1;
        settle();
        advance();
        idle();
        settle();
        check("t6_iv", 64'(issue_valid), 64'd0);
        check("t6_free", 64'(free_count), 64'd16);
        advance();

        // Randomized traffic against the model
        pl_ctr = 64'h1000;
        for (int c = 0; c < 3000; c++) begin
            idle();
            for (int l = 0; l < DW; l++) begin
                if ($urandom_range(0, 1) == 1) begin
                    set_lane(l, 1'($urandom_range(0, 1)), 6'($urandom_range(0, 7)),
                             1'($urandom_range(0, 1)), 6'($urandom_range(0, 7)),
                             3'($urandom_range(1, 7)), pl_ctr);
                    pl_ctr = pl_ctr + 64'd1;
                end
            end
            for (int w = 0; w < WW; w++) begin
                wb_valid[w] = ($urandom_range(0, 2) == 0);
                wb_tag[w]   = 6'($urandom_range(0, 7));
            end
            for (int p = 0; p < NI; p++) issue_ready[p] = ($urandom_range(0, 3) != 0);
            flush = ($urandom_range(0, 99) == 0);
            settle();
            advance();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/issue_queue_age.md
# issue_queue_age

Parametrised, age-ordered issue queue for the integer backend, placed between dispatch and the execution pipes/PRF read stage. Extends the fixed-size integer issue queue with configurable depth and widths, tag-broadcast wakeup, oldest-first selection per issue port through an age matrix, and per-port ready/valid back-pressure. Payload is opaque; the block tracks only operand tags, readiness, port eligibility and age.

## Interface
- ENTRIES, 16: queue slots (≥ DISPATCH_WIDTH, ≥ 2)
- DISPATCH_WIDTH, 4: dispatch lanes per cycle
- ISSUE_WIDTH, 3: issue ports
- WB_WIDTH, 3: wakeup broadcast ports
- TAG_W, 6: physical register tag width
- PAYLOAD_W, 64: opaque uop payload width

- clock  in  1  sole clock
- reset  in  1  synchronous, active-high
- flush  in  1  synchronous clear of all entries (mispredict/exception)
- dispatch_valid  in  [DISPATCH_WIDTH]  lane carries a uop; any bit pattern legal
- dispatch_ready  out  1  queue can accept a full dispatch group this cycle
- dispatch_rs1_tag, dispatch_rs2_tag  in  [DISPATCH_WIDTH][TAG_W]  source tags
- dispatch_rs1_rdy, dispatch_rs2_rdy  in  [DISPATCH_WIDTH]  operand already available (imm/x0/ready)
- dispatch_port_mask  in  [DISPATCH_WIDTH][ISSUE_WIDTH]  ports allowed to execute the uop; never 0 when valid
- dispatch_payload  in  [DISPATCH_WIDTH][PAYLOAD_W]
- wb_valid  in  [WB_WIDTH]; wb_tag  in  [WB_WIDTH][TAG_W]  wakeup broadcasts
- issue_valid  out  [ISSUE_WIDTH]; issue_ready  in  [ISSUE_WIDTH]  issue handshake (issue_ready low = pipe busy)
- issue_payload  out  [ISSUE_WIDTH][PAYLOAD_W]
- free_count  out  [$clog2(ENTRIES)+1]  registered free slot count

## Operation
- Entry state: valid, rs1_rdy, rs2_rdy, rs1_tag, rs2_tag, port_mask, payload; age matrix older[i][j] = entry i older than j.
- dispatch_ready = (free_count ≥ DISPATCH_WIDTH). Dispatch fires when dispatch_ready & any dispatch_valid & ~flush; lanes with dispatch_valid=1 go, in lane order, to the lowest-indexed free slots. dispatch_valid while dispatch_ready=0 is ignored (no state change).
- Age: a newly written entry is younger than every resident entry; among one cycle's group, lower lane is older. On write of entry k: older[k][*]=0, older[*][k]=valid[*] plus earlier lanes of the same group.
- Wakeup: each cycle every valid entry sets rsN_rdy if any wb_valid[w] & wb_tag[w]==rsN_tag. Dispatching lanes also compare against the same-cycle wb ports, so a tag broadcast in the dispatch cycle is never lost.
- Request: entry eligible for port p = valid & rs1_rdy & rs2_rdy & port_mask[p] & not granted to a lower-numbered port this cycle. Port p grants the oldest eligible entry (no eligible entry older). Ports resolve serially 0..ISSUE_WIDTH-1.
- Port p with issue_ready[p]=0 grants nothing; its candidate stays available to higher ports.
- Entry freed at clock edge when issue_valid[p] & issue_ready[p]; payload unchanged while resident.
- free_count register: next = current − dispatched count + issued count; flush/reset load ENTRIES.
- flush beats dispatch and issue in the same cycle; wakeups that cycle are discarded.

## Timing
- Reset/flush values: all entries invalid, age matrix 0, free_count=ENTRIES, dispatch_ready=1, issue_valid=0, issue_payload=0.
- Dispatch at edge N → entry issuable in cycle N+1 earliest (issue_valid combinational from registered state).
- Wakeup in cycle N → dependent entry issuable cycle N+1 (baseline; see Configuration).
- issue_valid[p] may depend combinationally on issue_ready[p]; issue_payload valid only with issue_valid.
- dispatch_ready depends only on registered free_count (no same-cycle issue credit).
- Full: free_count < DISPATCH_WIDTH → dispatch_ready=0 even if some slots free.

## Configuration
- IQ_BYPASS_WAKEUP_EN defined: eligibility uses rsN_rdy OR same-cycle wb match, so a wakeup in cycle N allows issue in cycle N (back-to-back dependent issue). Not defined: wakeup only updates registered ready bits; issue no earlier than N+1. Dispatch-cycle capture behaves identically in both builds.

## Test plan
- Reset, dispatch 4 ready ALU uops (mask 3'b111) payloads 1..4 → next cycle issue_payload = {1,2,3}, following cycle {4,-,-}; free_count 16→12→15→16.
- Fill 16 entries with rs1_rdy=0 tag 5 → dispatch_ready=0 at free_count 0..3; wb_tag=5 cycle N → 3 oldest issue cycle N+1 (N with IQ_BYPASS_WAKEUP_EN).
- Entries dispatched in order A(mask 001),B(001),C(111) all ready → port0=A, port1=C, port2 idle; next cycle port0=B.
- issue_ready=3'b010 with 3 ready mask-111 entries → only port1 valid, issuing oldest; others retained, age order preserved.
- Dispatch same cycle as wb_tag matching dispatch_rs2_tag, rs2_rdy=0 → entry issues next cycle, not stuck.
- flush concurrent with dispatch of 4 and issue_ready=111 → all issue_valid=0 next cycle, free_count=16, dispatched uops absent.
